// File: rtl/spi_burst_memory.sv
// Purpose : SPI-slave (mode 0) burst memory with address auto-increment, wrap, write protect and per-transaction status.
// Latency : sclk/cs_n/mosi pass SYNC_STAGES synchroniser flops plus one state flop; busy follows synchronised cs_n in SYNC_STAGES+1 clk.
// Backpress: none; the SPI master paces the link and must hold each SCLK half-period for at least SYNC_STAGES+3 clk cycles.
// Ports   : clk/reset_n       - core clock, asynchronous active-low reset
//           sclk/cs_n/mosi    - SPI pins from the pad (asynchronous to clk)
//           miso/miso_oe      - serial read data and pad tristate enable (1 = drive)
//           wp                - write protect; suppresses data writes
//           busy/wp_violation/word_count - transaction status
module spi_burst_memory #(
    parameter int ADDR_WIDTH  = 7,
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic                  wp,
    output logic                  busy,
    output logic                  wp_violation,
    output logic [ADDR_WIDTH:0]   word_count
);

    localparam int DEPTH    = 2 ** ADDR_WIDTH;
    localparam int CMD_BITS = ADDR_WIDTH + 1;
    localparam int SHW      = (CMD_BITS > DATA_WIDTH) ? CMD_BITS : DATA_WIDTH;
    localparam int CNT_W    = $clog2(SHW + 1);

    localparam logic [CNT_W-1:0]      CMD_LAST  = CNT_W'(CMD_BITS - 1);
    localparam logic [CNT_W-1:0]      DATA_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0]      CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   WC_ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, CMD, READ, WRITE} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   cs_prev_q,   cs_prev_d;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [SHW-2:0]         rx_q, rx_d;
    logic [DATA_WIDTH-1:0]  tx_q, tx_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic                   miso_q, miso_d;
    logic                   miso_oe_q, miso_oe_d;
    logic                   busy_q, busy_d;
    logic                   wp_viol_q, wp_viol_d;
    logic [ADDR_WIDTH:0]    word_cnt_q, word_cnt_d;

    logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
    logic                   mem_we;
    logic [DATA_WIDTH-1:0]  mem_wdata;

    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_fall;
    logic [SHW-1:0]         rx_next;
    logic [ADDR_WIDTH-1:0]  cmd_addr, addr_inc;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    // cs_n chain and cs_prev reset to "low": a falling edge is only seen after
    // cs_n has been observed high, so cs_n held low across reset release is ignored.
    assign cs_fall   = cs_prev_q & ~cs_s;
    assign rx_next   = {rx_q, mosi_s};
    assign cmd_addr  = rx_next[ADDR_WIDTH:1];
    assign addr_inc  = addr_q + ADDR_ONE;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        sclk_prev_d = sclk_s;
        cs_prev_d   = cs_s;
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        addr_d      = addr_q;
        miso_d      = miso_q;
        miso_oe_d   = miso_oe_q;
        wp_viol_d   = wp_viol_q;
        word_cnt_d  = word_cnt_q;
        mem_we      = 1'b0;
        mem_wdata   = rx_next[DATA_WIDTH-1:0];

        // Deasserted chip select overrides any same-cycle SCLK edge.
        if (state_q != IDLE && cs_s) begin
            state_d   = IDLE;
            miso_oe_d = 1'b0;
            miso_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    miso_oe_d = 1'b0;
                    miso_d    = 1'b0;
                    if (cs_fall) begin
                        state_d    = CMD;
                        bit_cnt_d  = '0;
                        rx_d       = '0;
                        word_cnt_d = '0;
                        wp_viol_d  = 1'b0;
                    end
                end
                CMD: begin
                    if (sclk_rise) begin
                        rx_d = rx_next[SHW-2:0];
                        if (bit_cnt_q == CMD_LAST) begin
                            bit_cnt_d = '0;
                            addr_d    = cmd_addr;
                            if (rx_next[0]) begin
                                state_d = READ;
                                tx_d    = mem_q[cmd_addr];
                            end else begin
                                state_d = WRITE;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_ONE;
                        end
                    end
                end
                READ: begin
                    if (sclk_fall) begin
                        miso_d    = tx_q[DATA_WIDTH-1];
                        tx_d      = {tx_q[DATA_WIDTH-2:0], 1'b0};
                        miso_oe_d = 1'b1;
                    end
                    if (sclk_rise) begin
                        if (bit_cnt_q == DATA_LAST) begin
                            bit_cnt_d = '0;
                            addr_d    = addr_inc;
                            tx_d      = mem_q[addr_inc];
                            if (word_cnt_q != '1) word_cnt_d = word_cnt_q + WC_ONE;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_ONE;
                        end
                    end
                end
                WRITE: begin
                    miso_oe_d = 1'b0;
                    if (sclk_rise) begin
                        rx_d = rx_next[SHW-2:0];
                        if (bit_cnt_q == DATA_LAST) begin
                            bit_cnt_d = '0;
                            if (wp) wp_viol_d = 1'b1;
                            else    mem_we    = 1'b1;
                            addr_d = addr_inc;
                            if (word_cnt_q != '1) word_cnt_d = word_cnt_q + WC_ONE;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_ONE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b0;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            addr_q      <= '0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            busy_q      <= 1'b0;
            wp_viol_q   <= 1'b0;
            word_cnt_q  <= '0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            addr_q      <= addr_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
            busy_q      <= busy_d;
            wp_viol_q   <= wp_viol_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    // Storage array is deliberately not reset so completed writes survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[addr_q] <= mem_wdata;
    end

    assign miso         = miso_q;
    assign miso_oe      = miso_oe_q;
    assign busy         = busy_q;
    assign wp_violation = wp_viol_q;
    assign word_count   = word_cnt_q;

endmodule

// File: tb/tb_spi_burst_memory.sv
// Purpose : self-checking bench for spi_burst_memory (default and AW=4/DW=16 instances).
// Latency : SPI bit time is 2*HALF clk cycles, well above the minimum half-period.
// Backpress: none; the bench acts as SPI master.
module tb_spi_burst_memory;

    localparam int HALF = 8;
    localparam int SYNC = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       sclk0, cs0, mosi0, wp0, miso0, oe0, busy0, viol0;
    logic [7:0] wc0;
    logic       sclk1, cs1, mosi1, wp1, miso1, oe1, busy1, viol1;
    logic [4:0] wc1;

    spi_burst_memory dut0 (
        .clk(clk), .reset_n(reset_n), .sclk(sclk0), .cs_n(cs0), .mosi(mosi0),
        .miso(miso0), .miso_oe(oe0), .wp(wp0), .busy(busy0),
        .wp_violation(viol0), .word_count(wc0)
    );

    spi_burst_memory #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .SYNC_STAGES(SYNC)) dut1 (
        .clk(clk), .reset_n(reset_n), .sclk(sclk1), .cs_n(cs1), .mosi(mosi1),
        .miso(miso1), .miso_oe(oe1), .wp(wp1), .busy(busy1),
        .wp_violation(viol1), .word_count(wc1)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural memory images, one per instance.
    logic [15:0] m0 [128];
    logic [15:0] m1 [16];
    logic [15:0] wq [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int aw(input int s); return (s != 0) ? 4 : 7; endfunction
    function automatic int dw(input int s); return (s != 0) ? 16 : 8; endfunction
    function automatic int depth(input int s); return 1 << aw(s); endfunction
    function automatic int wcmax(input int s); return (1 << (aw(s) + 1)) - 1; endfunction

    task automatic tick(input int n); repeat (n) @(negedge clk); endtask

    task automatic drv_sclk(input int s, input logic v); if (s != 0) sclk1 = v; else sclk0 = v; endtask
    task automatic drv_cs(input int s, input logic v);   if (s != 0) cs1 = v;   else cs0 = v;   endtask
    task automatic drv_mosi(input int s, input logic v); if (s != 0) mosi1 = v; else mosi0 = v; endtask
    task automatic drv_wp(input int s, input logic v);   if (s != 0) wp1 = v;   else wp0 = v;   endtask

    function automatic logic [31:0] obs_busy(input int s); return {31'b0, (s != 0) ? busy1 : busy0}; endfunction
    function automatic logic [31:0] obs_oe(input int s);   return {31'b0, (s != 0) ? oe1 : oe0}; endfunction
    function automatic logic [31:0] obs_viol(input int s); return {31'b0, (s != 0) ? viol1 : viol0}; endfunction
    function automatic logic [31:0] obs_wc(input int s);   return (s != 0) ? {27'b0, wc1} : {24'b0, wc0}; endfunction

    // One mode-0 bit: present mosi, sample miso just before the rising edge.
    task automatic spi_bit(input int s, input logic b, output logic r);
        drv_mosi(s, b);
        tick(HALF);
        r = (s != 0) ? miso1 : miso0;
        drv_sclk(s, 1'b1);
        tick(HALF);
        drv_sclk(s, 1'b0);
    endtask

    task automatic spi_frame(input int s, input int n, input logic [31:0] v, output logic [31:0] rv);
        logic r;
        rv = '0;
        for (int i = n - 1; i >= 0; i--) begin
            spi_bit(s, v[i], r);
            rv = {rv[30:0], r};
        end
    endtask

    task automatic txn_begin(input int s);
        drv_cs(s, 1'b0);
        tick(HALF);
        chk("begin_busy", obs_busy(s), 32'd1);
        chk("begin_wc_clr", obs_wc(s), 32'd0);
        chk("begin_viol_clr", obs_viol(s), 32'd0);
    endtask

    task automatic txn_end(input int s);
        tick(HALF);
        drv_cs(s, 1'b1);
        tick(2 * HALF);
    endtask

    task automatic send_cmd(input int s, input int addr, input logic rw);
        logic [31:0] rv;
        spi_frame(s, aw(s) + 1, (32'(addr) << 1) | {31'b0, rw}, rv);
    endtask

    task automatic do_write(input int s, input int addr, input int n, input logic wpv);
        logic [31:0] rv;
        logic [15:0] d;
        int a;
        logic viol;
        drv_wp(s, wpv);
        txn_begin(s);
        send_cmd(s, addr, 1'b0);
        a = addr;
        viol = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (wq.size() > 0) d = wq.pop_front();
            else d = 16'($urandom);
            if (s == 0) d[15:8] = 8'h00;
            spi_frame(s, dw(s), {16'b0, d}, rv);
            if (wpv) viol = 1'b1;
            else if (s != 0) m1[a] = d;
            else m0[a] = d;
            a = (a + 1) % depth(s);
        end
        txn_end(s);
        chk("wr_word_count", obs_wc(s), 32'((n < wcmax(s)) ? n : wcmax(s)));
        chk("wr_wp_violation", obs_viol(s), {31'b0, viol});
        chk("wr_oe_idle", obs_oe(s), 32'd0);
        drv_wp(s, 1'b0);
    endtask

    task automatic do_read(input int s, input int addr, input int n);
        logic [31:0] rv;
        int a;
        txn_begin(s);
        send_cmd(s, addr, 1'b1);
        a = addr;
        for (int i = 0; i < n; i++) begin
            spi_frame(s, dw(s), 32'd0, rv);
            chk("rd_data", rv, {16'b0, (s != 0) ? m1[a] : m0[a]});
            a = (a + 1) % depth(s);
        end
        chk("rd_oe_active", obs_oe(s), 32'd1);
        txn_end(s);
        chk("rd_word_count", obs_wc(s), 32'(n));
        chk("rd_oe_released", obs_oe(s), 32'd0);
        chk("rd_busy_released", obs_busy(s), 32'd0);
    endtask

    initial begin
        logic        r;
        logic [31:0] rv;
        int          a, n;

        reset_n = 1'b0;
        {sclk0, mosi0, wp0, sclk1, mosi1, wp1} = '0;
        cs0 = 1'b1;
        cs1 = 1'b1;
        tick(3);
        for (int s = 0; s < 2; s++) begin
            chk("rst_miso", {31'b0, (s != 0) ? miso1 : miso0}, 32'd0);
            chk("rst_oe", obs_oe(s), 32'd0);
            chk("rst_busy", obs_busy(s), 32'd0);
            chk("rst_viol", obs_viol(s), 32'd0);
            chk("rst_wc", obs_wc(s), 32'd0);
        end
        reset_n = 1'b1;
        tick(10);

        // Fill both memories so every later read has a known expectation.
        do_write(0, 0, 128, 1'b0);
        do_write(1, 0, 16, 1'b0);

        // Burst write then read back at 0x10.
        wq = '{16'hA5, 16'h5A, 16'h3C};
        do_write(0, 'h10, 3, 1'b0);
        chk("burst_mem_10", {16'b0, m0['h10]}, 32'hA5);
        do_read(0, 'h10, 3);

        // Address wrap 0x7F -> 0x00.
        wq = '{16'h11, 16'h22};
        do_write(0, 'h7F, 2, 1'b0);
        do_read(0, 'h7F, 2);
        do_read(0, 'h00, 1);

        // Aborted write frame after 5 data bits.
        txn_begin(0);
        send_cmd(0, 'h20, 1'b0);
        for (int i = 0; i < 5; i++) spi_bit(0, 1'($urandom), r);
        drv_cs(0, 1'b1);
        tick(SYNC + 2);
        chk("abort_oe", obs_oe(0), 32'd0);
        chk("abort_busy", obs_busy(0), 32'd0);
        chk("abort_wc", obs_wc(0), 32'd0);
        tick(2 * HALF);
        do_read(0, 'h20, 1);

        // Write protect: data untouched, sticky flag until next select.
        wq = '{16'hFF};
        do_write(0, 'h05, 1, 1'b1);
        tick(4 * HALF);
        chk("wp_sticky", obs_viol(0), 32'd1);
        do_read(0, 'h05, 1);

        // Randomised bursts against the model.
        for (int k = 0; k < 8; k++) begin
            a = int'($urandom_range(0, 127));
            n = int'($urandom_range(1, 5));
            if ($urandom_range(0, 1) == 0) do_write(0, a, n, $urandom_range(0, 3) == 0);
            else do_read(0, a, n);
        end

        // Reset during the 3rd bit of a read data frame.
        txn_begin(0);
        send_cmd(0, 'h10, 1'b1);
        spi_bit(0, 1'b0, r);
        spi_bit(0, 1'b0, r);
        drv_sclk(0, 1'b1);
        tick(3);
        reset_n = 1'b0;
        #1;
        chk("midrst_oe", obs_oe(0), 32'd0);
        chk("midrst_miso", {31'b0, miso0}, 32'd0);
        chk("midrst_busy", obs_busy(0), 32'd0);
        chk("midrst_wc", obs_wc(0), 32'd0);
        chk("midrst_viol", obs_viol(0), 32'd0);
        tick(3);
        drv_sclk(0, 1'b0);
        reset_n = 1'b1;
        // cs_n still low at release: must not open a transaction.
        for (int i = 0; i < 6; i++) spi_bit(0, 1'b1, r);
        chk("post_rst_busy", obs_busy(0), 32'd0);
        chk("post_rst_oe", obs_oe(0), 32'd0);
        drv_cs(0, 1'b1);
        tick(2 * HALF);
        do_read(0, 'h10, 3);

        // Wide-data, narrow-address instance.
        wq = '{16'hBEEF, 16'h1234};
        do_write(1, 'hF, 2, 1'b0);
        chk("p_mem_0", {16'b0, m1[0]}, 32'h1234);
        do_read(1, 'hF, 2);
        do_write(1, 3, 40, 1'b0);
        do_read(1, int'($urandom_range(0, 15)), 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_burst_memory.md
Name: spi_burst_memory

Overview:
- Parametrised SPI-slave memory: next generation of the team's single-byte SPI memory.
- Adds configurable address/data width, burst transfers with address auto-increment and wrap, a write-protect input, and per-transaction status.
- Sits between the board SPI pins (via the top-level tristate pad) and an internal register-array memory.
- Fully synchronous to the FPGA clock. SCLK, CS and MOSI are synchronised and edge-detected internally.

Parameters:
- ADDR_WIDTH, 7, address bits; memory DEPTH = 2**ADDR_WIDTH words.
- DATA_WIDTH, 8, bits per data word and per data frame.
- SYNC_STAGES, 2, flip-flop synchroniser depth on sclk, cs_n and mosi (minimum 2).

Ports:
- clk  in  1  FPGA clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- sclk  in  1  SPI clock, mode 0 (idle low).
- cs_n  in  1  SPI chip select, active low.
- mosi  in  1  master out slave in.
- miso  out  1  serial data to the pad tristate.
- miso_oe  out  1  pad tristate enable; 1 = drive.
- wp  in  1  write protect; 1 = data writes suppressed.
- busy  out  1  high while a transaction is active (synchronised cs_n low).
- wp_violation  out  1  sticky: a write frame completed while wp = 1.
- word_count  out  ADDR_WIDTH+1  data frames completed in the current or most recent transaction; saturates at all-ones.

Behaviour:
- Reset (async assert, sync release):
  - Outputs: miso = 0, miso_oe = 0, busy = 0, wp_violation = 0, word_count = 0.
  - Internal: state = IDLE, shift and bit counters cleared.
  - Memory contents are not reset.
- Sampling and timing:
  - Synchronised rising SCLK edge: sample mosi into rx shift register, MSB first.
  - Synchronised falling SCLK edge: update miso from tx shift register MSB.
  - SCLK half-period must be at least SYNC_STAGES+3 clk cycles.
- Frames:
  - Command frame: ADDR_WIDTH+1 bits = address (MSB first) followed by R/W bit (1 = read, 0 = write).
  - Then any number of DATA_WIDTH-bit data frames while cs_n stays low.
- States:
  - IDLE: miso_oe = 0. On cs_n falling: clear bit counter, word_count and wp_violation; go to CMD.
  - CMD: shift ADDR_WIDTH+1 bits. On the last bit, latch the address into the address register, then go to READ or WRITE.
  - READ:
    - Entry or frame completion: load tx register with mem[addr] (asynchronous array read) in the same clk cycle as the completing rising-edge detect.
    - miso_oe = 1 from the first falling edge after the command, so the MSB is valid before the next rising edge.
    - After each DATA_WIDTH bits: addr increments, word_count increments, tx reloads.
  - WRITE:
    - After each DATA_WIDTH bits: if wp = 0, mem[addr] <= rx in one clk cycle; else set wp_violation and leave memory unchanged.
    - addr increments and word_count increments in both cases.
    - miso_oe = 0 throughout.
- Address increment: addr wraps DEPTH-1 -> 0 in both modes.
- Chip-select release:
  - cs_n high in any state: go to IDLE within 1 clk of the synchronised edge; miso_oe = 0.
  - Partial write frame: discarded, memory unchanged.
  - Partial command frame: no access.
  - word_count and wp_violation hold their values until the next cs_n falling edge.
- Simultaneous events:
  - cs_n rising and an SCLK edge in the same cycle: cs_n wins; the edge is ignored.
  - A write commit on the completing edge has priority over the same-cycle read of that address; reads in later frames see the new data.
- Reset mid-transaction: everything returns to the reset state immediately. Completed writes persist; the in-flight frame is lost. Once reset_n is released, a new transaction starts only after a cs_n falling edge; cs_n already low at release is ignored until it goes high, then low.
- busy tracks synchronised cs_n low; latency SYNC_STAGES+1 clk cycles.

Test Plan:
- Burst write/read (defaults): write command addr 0x10, data A5, 5A, 3C; then read from 0x10 for 3 frames. Required: miso returns A5, 5A, 3C; word_count = 3 after each transaction.
- Wrap-around: write to 0x7F with data 11, 22; read 0x7F for 2 frames. Required: 11 then 22, with mem[0x00] = 22.
- Aborted frame: write command to 0x20, then 5 data bits, then cs_n high. Required: mem[0x20] unchanged; miso_oe = 0 and busy = 0 within SYNC_STAGES+2 clk cycles.
- Write protect: wp = 1, write 0xFF to 0x05. Required: mem[0x05] keeps its prior value and wp_violation = 1. The next cs_n falling edge clears it.
- Reset mid-read: assert reset_n low during the 3rd bit of a read frame. Required: miso_oe = 0 and all outputs at reset values; previously written data is intact on a subsequent read.
- Parameter sweep: ADDR_WIDTH = 4, DATA_WIDTH = 16. Write 0xBEEF to 0xF, then 0x1234 (wraps to 0x0); read back both. word_count saturates at 31 after a 40-frame burst.
